fifo_param: RTL

Parametrised synchronous FIFO, the successor to the fixed 8x4 FIFO. It adds a generic width and depth, a first-word-fall-through (FWFT) mode, an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow errors. All flags are zero-lag: they reflect the state after the same edge that moves the pointers. It sits between producer and consumer stages in a single clock domain.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_param_if.sv | 33 +++
 rtl/fifo_ram.sv | 22 ++
 rtl/fifo_param.sv | 117 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy ranges over 0..DEPTH, so one bit more than the address is needed.
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer handshake bundle for fifo_param; slave is the FIFO side.
interface fifo_param_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
);
  import fifo_pkg::*;

  localparam int CNT_W = cnt_width(ADDR_W);

  logic              wr_vld;
  logic [DATA_W-1:0] wr_data;
  logic              rd_vld;
  logic [DATA_W-1:0] rd_data;
  logic              wr_full;
  logic              rd_empty;
  logic [CNT_W-1:0]  count;
  logic              almost_full;
  logic              almost_empty;
  logic              err_clr;
  logic              wr_ovf;
  logic              rd_udf;

  modport master (
    output wr_vld, wr_data, rd_vld, err_clr,
    input  rd_data, wr_full, rd_empty, count, almost_full, almost_empty, wr_ovf, rd_udf
  );

  modport slave (
    input  wr_vld, wr_data, rd_vld, err_clr,
    output rd_data, wr_full, rd_empty, count, almost_full, almost_empty, wr_ovf, rd_udf
  );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through output,
// occupancy count, almost flags and sticky overflow/underflow errors.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 3,
  parameter int MODE      = FIFO_MODE_STD,
  parameter int AFULL_TH  = (2**ADDR_W) - 2,
  parameter int AEMPTY_TH = 1
) (
  input logic         clk,
  input logic         rst_n,
  fifo_param_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = cnt_width(ADDR_W);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_full_q, wr_full_d, rd_empty_q, rd_empty_d;
  logic              afull_q, afull_d, aempty_q, aempty_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc, rd_acc, mem_empty, mem_we;
  logic [DATA_W-1:0] mem_rdata;

  fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wr_acc    = bus.wr_vld && !wr_full_q;
    rd_acc    = bus.rd_vld && !rd_empty_q;
    mem_empty = (wr_ptr_q == rd_ptr_q);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    mem_we    = 1'b0;

    if (MODE == FIFO_MODE_FWFT) begin
      // The output register is the head word; memory only holds the words behind it.
      if (rd_acc) begin
        if (!mem_empty) begin
          rd_data_d = mem_rdata;
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          mem_we    = wr_acc;
        end else if (wr_acc) begin
          rd_data_d = bus.wr_data;
        end
      end else if (wr_acc) begin
        if (rd_empty_q) rd_data_d = bus.wr_data;
        else            mem_we    = 1'b1;
      end
    end else begin
      mem_we = wr_acc;
      if (rd_acc) begin
        rd_data_d = mem_rdata;
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
      end
    end

    if (mem_we) wr_ptr_d = wr_ptr_q + PTR_ONE;

    // Flags come from the next-state count so they carry no extra cycle of lag.
    count_d    = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    wr_full_d  = (count_d == CNT_W'(DEPTH));
    rd_empty_d = (count_d == '0);
    afull_d    = (count_d >= CNT_W'(AFULL_TH));
    aempty_d   = (count_d <= CNT_W'(AEMPTY_TH));
    ovf_d      = (bus.wr_vld && wr_full_q)  || (ovf_q && !bus.err_clr);
    udf_d      = (bus.rd_vld && rd_empty_q) || (udf_q && !bus.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      wr_full_q  <= 1'b0;
      rd_empty_q <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      wr_full_q  <= wr_full_d;
      rd_empty_q <= rd_empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.count        = count_q;
  assign bus.wr_full      = wr_full_q;
  assign bus.rd_empty     = rd_empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.wr_ovf       = ovf_q;
  assign bus.rd_udf       = udf_q;

endmodule
